// File: rtl/wb_block_stat_if.sv
// Pixel stream bus for the block statistics engine: luminance plus the
// vertical/horizontal active windows, driven by the timing source.
interface wb_block_stat_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] iPixelData;
    logic              iV_Duty;
    logic              iH_Duty;

    modport master (output iPixelData, iV_Duty, iH_Duty);
    modport slave  (input  iPixelData, iV_Duty, iH_Duty);
endinterface

// File: rtl/wb_block_stat.sv
// Per-frame, per-zone white/black statistics: counts pixels above a latched
// threshold and tracks the peak per horizontal zone, publishing at frame end.
module wb_block_stat #(
    parameter int DATA_W  = 8,
    parameter int NUM_BLK = 8,
    parameter int BLK_W   = 240,
    parameter int CNT_W   = 20
) (
    input  logic                      iODCK,
    input  logic                      iRST,
    wb_block_stat_if.slave            pixBus,
    input  logic [DATA_W-1:0]         iSWthreshold,
    input  logic [CNT_W-1:0]          iMinCount,
    input  logic                      iMode,
    output logic [NUM_BLK-1:0]        oBlockFlag,
    output logic [NUM_BLK*CNT_W-1:0]  oBlockCount,
    output logic [NUM_BLK*DATA_W-1:0] oBlockMax,
    output logic                      oFrameValid
);
    localparam int BLK_IW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam int PIX_W  = (BLK_W > 1) ? $clog2(BLK_W) : 1;

    logic              vPrev;
    logic              hPrev;
    logic [PIX_W-1:0]  pix;
    logic [BLK_IW-1:0] blk;
    logic [DATA_W-1:0] thrLat;
    logic [CNT_W-1:0]  minCountLat;
    logic              modeLat;
    logic [CNT_W-1:0]  cnt [NUM_BLK];
    logic [DATA_W-1:0] mx  [NUM_BLK];

    logic              active;
    logic              frameStart;
    logic              frameEnd;
    logic              lineEnd;
    logic [DATA_W-1:0] thrEff;

    always_comb begin
        active     = pixBus.iV_Duty & pixBus.iH_Duty;
        frameStart = pixBus.iV_Duty & ~vPrev;
        frameEnd   = ~pixBus.iV_Duty & vPrev;
        lineEnd    = ~pixBus.iH_Duty & hPrev;
        // a pixel on the frame-start edge must already see the new threshold
        thrEff     = frameStart ? iSWthreshold : thrLat;
    end

    always_ff @(posedge iODCK or posedge iRST) begin
        if (iRST) begin
            vPrev       <= 1'b0;
            hPrev       <= 1'b0;
            pix         <= '0;
            blk         <= '0;
            thrLat      <= '0;
            minCountLat <= '0;
            modeLat     <= 1'b0;
            oBlockFlag  <= '0;
            oBlockCount <= '0;
            oBlockMax   <= '0;
            oFrameValid <= 1'b0;
            for (int unsigned b = 0; b < NUM_BLK; b++) begin
                cnt[b] <= '0;
                mx[b]  <= '0;
            end
        end else begin
            vPrev       <= pixBus.iV_Duty;
            hPrev       <= pixBus.iH_Duty;
            oFrameValid <= 1'b0;

            if (frameStart) begin
                thrLat      <= iSWthreshold;
                minCountLat <= iMinCount;
                modeLat     <= iMode;
            end

            if (frameEnd) begin
                for (int unsigned b = 0; b < NUM_BLK; b++) begin
                    oBlockCount[b*CNT_W +: CNT_W]   <= cnt[b];
                    oBlockMax[b*DATA_W +: DATA_W]   <= mx[b];
                    oBlockFlag[b] <= modeLat ? (cnt[b] >= minCountLat) : (cnt[b] != '0);
                    cnt[b] <= '0;
                    mx[b]  <= '0;
                end
                oFrameValid <= 1'b1;
            end else if (active) begin
                if ((pixBus.iPixelData > thrEff) && (cnt[blk] != '1))
                    cnt[blk] <= cnt[blk] + CNT_W'(1);
                if (pixBus.iPixelData > mx[blk])
                    mx[blk] <= pixBus.iPixelData;
            end

            // overflow pixels past the last zone boundary stay in the last zone
            if (frameEnd || lineEnd) begin
                pix <= '0;
                blk <= '0;
            end else if (active) begin
                if (pix == PIX_W'(BLK_W - 1)) begin
                    pix <= '0;
                    if (blk != BLK_IW'(NUM_BLK - 1))
                        blk <= blk + BLK_IW'(1);
                end else begin
                    pix <= pix + PIX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_block_stat.sv
// Scoreboard bench for wb_block_stat: two instances (wide and 2-bit counters)
// share one pixel bus; a position-based model predicts each published frame.
module tb_wb_block_stat;
    localparam int DW = 8;
    localparam int NB = 4;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_block_stat_if #(.DATA_W(DW)) bus ();

    logic [DW-1:0]    thr;
    logic [7:0]       minA;
    logic [1:0]       minB;
    logic             mode;
    logic [NB-1:0]    flagA, flagB;
    logic [NB*8-1:0]  cntA;
    logic [NB*2-1:0]  cntB;
    logic [NB*DW-1:0] maxA, maxB;
    logic             fvA, fvB;

    wb_block_stat #(.DATA_W(DW), .NUM_BLK(NB), .BLK_W(BW), .CNT_W(8)) dutA (
        .iODCK(clk), .iRST(rst), .pixBus(bus), .iSWthreshold(thr),
        .iMinCount(minA), .iMode(mode), .oBlockFlag(flagA),
        .oBlockCount(cntA), .oBlockMax(maxA), .oFrameValid(fvA));

    wb_block_stat #(.DATA_W(DW), .NUM_BLK(NB), .BLK_W(BW), .CNT_W(2)) dutB (
        .iODCK(clk), .iRST(rst), .pixBus(bus), .iSWthreshold(thr),
        .iMinCount(minB), .iMode(mode), .oBlockFlag(flagB),
        .oBlockCount(cntB), .oBlockMax(maxB), .oFrameValid(fvB));

    typedef struct {
        logic [NB-1:0]    flagA;
        logic [NB*8-1:0]  cntA;
        logic [NB-1:0]    flagB;
        logic [NB*2-1:0]  cntB;
        logic [NB*DW-1:0] maxv;
    } exp_t;

    exp_t expQ[$];
    exp_t lastExp;
    int   checks = 0;
    int   errors = 0;
    int   pulsesA = 0;
    logic prevFv = 1'b0;

    int            mCnt [NB];
    int            mMax [NB];
    logic [DW-1:0] mThr;
    logic          mMode;
    int            mMinA, mMinB;
    logic [DW-1:0] lineBuf [32];

    // Scoreboard consumer: every publish pulse pops one predicted frame
    always @(negedge clk) begin
        if (fvA && prevFv) begin
            checks++;
            errors++;
            $display("FAIL valid_width: oFrameValid high two cycles, required one");
        end
        if (fvA !== fvB) begin
            checks++;
            errors++;
            $display("FAIL valid_pair: A=%b B=%b, required equal", fvA, fvB);
        end
        if (fvA === 1'b1) begin
            pulsesA++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_publish: pulse with no frame expected");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (flagA !== e.flagA || cntA !== e.cntA || maxA !== e.maxv ||
                    flagB !== e.flagB || cntB !== e.cntB || maxB !== e.maxv) begin
                    errors++;
                    $display("FAIL publish: flagA=%h cntA=%h maxA=%h flagB=%h cntB=%h maxB=%h required %h %h %h %h %h %h",
                             flagA, cntA, maxA, flagB, cntB, maxB,
                             e.flagA, e.cntA, e.maxv, e.flagB, e.cntB, e.maxv);
                end
            end
        end
        prevFv = fvA;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.iV_Duty = 1'b0;
            bus.iH_Duty = 1'b0;
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        bus.iV_Duty = 1'b1;
        bus.iH_Duty = 1'b0;
        mThr  = thr;
        mMode = mode;
        mMinA = int'(minA);
        mMinB = int'(minB);
        for (int b = 0; b < NB; b++) begin
            mCnt[b] = 0;
            mMax[b] = 0;
        end
    endtask

    task automatic drive_line(input int n);
        for (int i = 0; i < n; i++) begin
            int z;
            @(negedge clk);
            bus.iH_Duty    = 1'b1;
            bus.iPixelData = lineBuf[i];
            z = i / BW;
            if (z > NB - 1) z = NB - 1;
            if (lineBuf[i] > mThr) mCnt[z]++;
            if (int'(lineBuf[i]) > mMax[z]) mMax[z] = int'(lineBuf[i]);
        end
        @(negedge clk);
        bus.iH_Duty    = 1'b0;
        bus.iPixelData = '0;
    endtask

    task automatic push_expected();
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            int ca, cb;
            ca = (mCnt[b] > 255) ? 255 : mCnt[b];
            cb = (mCnt[b] > 3) ? 3 : mCnt[b];
            e.cntA[b*8 +: 8]   = 8'(ca);
            e.cntB[b*2 +: 2]   = 2'(cb);
            e.maxv[b*DW +: DW] = DW'(mMax[b]);
            e.flagA[b] = mMode ? (ca >= mMinA) : (ca != 0);
            e.flagB[b] = mMode ? (cb >= mMinB) : (cb != 0);
        end
        expQ.push_back(e);
        lastExp = e;
    endtask

    // Drops V and waits (bounded) for the publish pulse
    task automatic frame_end();
        int p0;
        bit seen;
        p0 = pulsesA;
        seen = 1'b0;
        @(negedge clk);
        bus.iV_Duty = 1'b0;
        bus.iH_Duty = 1'b0;
        push_expected();
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (pulsesA > p0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL publish_timeout: no oFrameValid within 8 cycles");
        end
    endtask

    task automatic fill(input int n, input logic [DW-1:0] v);
        for (int i = 0; i < n; i++) lineBuf[i] = v;
    endtask

    task automatic test_reset();
        bus.iV_Duty = 1'b0; bus.iH_Duty = 1'b0; bus.iPixelData = '0;
        thr = 8'h80; minA = '0; minB = '0; mode = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (flagA !== '0 || cntA !== '0 || maxA !== '0 || fvA !== 1'b0 ||
            flagB !== '0 || cntB !== '0 || maxB !== '0 || fvB !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: flag=%h cnt=%h max=%h fv=%b required all 0", flagA, cntA, maxA, fvA);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_any_pixel();
        thr = 8'h80; mode = 1'b0;
        fill(16, 8'h10);
        lineBuf[9] = 8'h81;
        frame_begin();
        drive_line(16);
        frame_end();
        checks++;
        if (flagA !== 4'b0100 || cntA[2*8 +: 8] !== 8'd1 || maxA[2*DW +: DW] !== 8'h81 ||
            maxA[0 +: DW] !== 8'h10) begin
            errors++;
            $display("FAIL any_pixel: flag=%b cnt2=%0d max2=%h max0=%h required 0100 1 81 10",
                     flagA, cntA[2*8 +: 8], maxA[2*DW +: DW], maxA[0 +: DW]);
        end
        idle(3);
    endtask

    task automatic test_count_mode();
        thr = 8'h80; mode = 1'b1; minA = 8'd3; minB = 2'd3;
        frame_begin();
        for (int l = 0; l < 3; l++) begin
            fill(16, 8'h10);
            lineBuf[0] = 8'h81;
            if (l < 2) lineBuf[4] = 8'h81;
            drive_line(16);
            idle(0);
        end
        frame_end();
        checks++;
        if (flagA[1:0] !== 2'b01 || cntA[0 +: 8] !== 8'd3 || cntA[8 +: 8] !== 8'd2) begin
            errors++;
            $display("FAIL count_mode: flag=%b cnt0=%0d cnt1=%0d required 01 3 2",
                     flagA[1:0], cntA[0 +: 8], cntA[8 +: 8]);
        end
        idle(3);
    endtask

    task automatic test_strict_sat();
        thr = 8'h80; mode = 1'b0;
        fill(8, 8'h00);
        for (int i = 0; i < 4; i++) lineBuf[i] = 8'h80;
        for (int i = 4; i < 8; i++) lineBuf[i] = 8'hFF;
        frame_begin();
        drive_line(8);
        lineBuf[6] = 8'h00; lineBuf[7] = 8'h00;
        drive_line(8);
        frame_end();
        checks++;
        if (cntB[0 +: 2] !== 2'd0 || cntB[2 +: 2] !== 2'd3 || maxB[DW +: DW] !== 8'hFF ||
            cntA[8 +: 8] !== 8'd6) begin
            errors++;
            $display("FAIL strict_sat: cnt0=%0d cnt1=%0d max1=%h cntA1=%0d required 0 3 FF 6",
                     cntB[0 +: 2], cntB[2 +: 2], maxB[DW +: DW], cntA[8 +: 8]);
        end
        idle(3);
    endtask

    task automatic test_long_line();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.iV_Duty = 1'b0; bus.iH_Duty = 1'b1; bus.iPixelData = 8'hFF;
        end
        idle(2);
        checks++;
        if (cntA !== lastExp.cntA || maxA !== lastExp.maxv || flagA !== lastExp.flagA) begin
            errors++;
            $display("FAIL h_without_v: cnt=%h max=%h flag=%h required %h %h %h",
                     cntA, maxA, flagA, lastExp.cntA, lastExp.maxv, lastExp.flagA);
        end
        thr = 8'h80; mode = 1'b0;
        fill(20, 8'h10);
        for (int i = 16; i < 20; i++) lineBuf[i] = 8'hFF;
        frame_begin();
        drive_line(20);
        frame_end();
        checks++;
        if (cntA[3*8 +: 8] !== 8'd4 || maxA[3*DW +: DW] !== 8'hFF || flagA !== 4'b1000) begin
            errors++;
            $display("FAIL long_line: cnt3=%0d max3=%h flag=%b required 4 FF 1000",
                     cntA[3*8 +: 8], maxA[3*DW +: DW], flagA);
        end
        idle(3);
    endtask

    task automatic test_threshold_latch();
        thr = 8'h80; mode = 1'b0;
        fill(16, 8'h40);
        frame_begin();
        drive_line(16);
        thr = 8'h00;
        drive_line(16);
        frame_end();
        checks++;
        if (flagA !== 4'b0000) begin
            errors++;
            $display("FAIL thr_current_frame: flag=%b required 0000", flagA);
        end
        idle(2);
        frame_begin();
        drive_line(16);
        frame_end();
        checks++;
        if (flagA !== 4'b1111 || cntA[0 +: 8] !== 8'd4) begin
            errors++;
            $display("FAIL thr_next_frame: flag=%b cnt0=%0d required 1111 4", flagA, cntA[0 +: 8]);
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        int p0;
        thr = 8'h80; mode = 1'b0;
        frame_begin();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.iH_Duty = 1'b1; bus.iPixelData = 8'hFF;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (flagA !== '0 || cntA !== '0 || maxA !== '0 || fvA !== 1'b0 ||
            cntB !== '0 || maxB !== '0) begin
            errors++;
            $display("FAIL reset_async: flag=%h cnt=%h max=%h fv=%b required all 0", flagA, cntA, maxA, fvA);
        end
        bus.iV_Duty = 1'b0; bus.iH_Duty = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(2);
        p0 = pulsesA;
        fill(16, 8'h20);
        lineBuf[13] = 8'h90;
        frame_begin();
        drive_line(16);
        frame_end();
        idle(4);
        checks++;
        if (pulsesA !== p0 + 1 || flagA !== 4'b1000 || maxA[0 +: DW] !== 8'h20) begin
            errors++;
            $display("FAIL reset_next_frame: pulses=%0d flag=%b max0=%h required %0d 1000 20",
                     pulsesA - p0, flagA, maxA[0 +: DW], 1);
        end
    endtask

    task automatic test_back_to_back();
        thr = 8'h30; mode = 1'b0;
        fill(16, 8'h31);
        frame_begin();
        drive_line(16);
        @(negedge clk);
        bus.iV_Duty = 1'b0;
        push_expected();
        fill(16, 8'h05);
        lineBuf[5] = 8'h77;
        frame_begin();
        drive_line(16);
        frame_end();
        idle(4);
    endtask

    initial begin
        test_reset();
        test_any_pixel();
        test_count_mode();
        test_strict_sat();
        test_long_line();
        test_threshold_latch();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames unpublished, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
